// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-outstanding AXI4-Lite master for MMU physical requests
// One request at a time: latch, run AR/R or AW+W/B, then pulse response_enable.

module mem_bus_master (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        response_enable,
  output logic [31:0] resp_data,
  output logic        bus_error,
  output logic        busy,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RADDR      = 3'd1,
    RDATA      = 3'd2,
    WADDR_DATA = 3'd3,
    WRESP      = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        mode_q, mode_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        resp_en_q, resp_en_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        bus_error_q, bus_error_d;
  logic        complete;
  logic        aw_hs;
  logic        w_hs;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    mode_d      = mode_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    resp_en_d   = 1'b0;
    resp_data_d = resp_data_q;
    bus_error_d = bus_error_q;
    complete    = 1'b0;
    aw_hs       = awvalid_q & m_axi_awready;
    w_hs        = wvalid_q & m_axi_wready;

    case (state_q)
      IDLE: begin
        if (request_enable) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          mode_d  = req_mode;
          if (req_mode) begin
            state_d   = WADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      RADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          complete = 1'b1;
        end
      end
      WADDR_DATA: begin
        // AW and W retire independently; B is only accepted once both have gone.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          complete = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (complete) begin
      state_d     = DONE;
      resp_en_d   = 1'b1;
      resp_data_d = mode_q ? 32'd0 : m_axi_rdata;
      bus_error_d = mode_q ? (m_axi_bresp != 2'b00) : (m_axi_rresp != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      mode_q      <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_en_q   <= 1'b0;
      resp_data_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      mode_q      <= mode_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      resp_en_q   <= resp_en_d;
      resp_data_q <= resp_data_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign response_enable = resp_en_q;
  assign resp_data       = resp_data_q;
  assign bus_error       = bus_error_q;
  assign m_axi_araddr    = addr_q;
  assign m_axi_arprot    = 3'b000;
  assign m_axi_arvalid   = arvalid_q;
  assign m_axi_rready    = rready_q;
  assign m_axi_awaddr    = addr_q;
  assign m_axi_awprot    = 3'b000;
  assign m_axi_awvalid   = awvalid_q;
  assign m_axi_wdata     = wdata_q;
  assign m_axi_wstrb     = wstrb_q;
  assign m_axi_wvalid    = wvalid_q;
  assign m_axi_bready    = bready_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - bench for mem_bus_master with a cycle-counting AXI-Lite slave
// Expected latency/data/error come from the transaction rules, not from DUT internals.

module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        request_enable = 1'b0;
  logic        req_mode = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        bus_error;
  logic        busy;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  mem_bus_master dut (
    .clk(clk), .rstn(rstn),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data), .bus_error(bus_error), .busy(busy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          inject;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } txn_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_read(input txn_t t);
    int n = 0;
    while (!m_axi_arvalid && n < 50) begin cyc(); n++; end
    repeat (t.ar_w) cyc();
    m_axi_arready = 1'b1;
    cyc();
    m_axi_arready = 1'b0;
    for (int i = 0; i < t.r_w; i++) begin
      // A stray request while busy must be dropped by the master.
      if (t.inject && i == 1) begin
        request_enable = 1'b1;
        req_addr       = 32'hBAD0_0000;
      end
      cyc();
      request_enable = 1'b0;
    end
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = t.rdata;
    m_axi_rresp  = t.resp;
    cyc();
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = $urandom;
    m_axi_rresp  = 2'b00;
  endtask

  task automatic slave_write(input txn_t t);
    fork
      begin
        int n = 0;
        while (!m_axi_awvalid && n < 50) begin cyc(); n++; end
        repeat (t.aw_w) cyc();
        m_axi_awready = 1'b1;
        cyc();
        m_axi_awready = 1'b0;
      end
      begin
        int n = 0;
        while (!m_axi_wvalid && n < 50) begin cyc(); n++; end
        repeat (t.w_w) cyc();
        m_axi_wready = 1'b1;
        cyc();
        m_axi_wready = 1'b0;
      end
    join
    repeat (t.b_w) cyc();
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = t.resp;
    cyc();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
  endtask

  task automatic run_txn(input txn_t t);
    int lat = 1;
    int arv = 0, awv = 0, wv = 0, rr = 0, br = 0, ar_hs = 0;
    int pay_bad = 0, busy_bad = 0, bviol = 0;
    bit awd = 0, wdn = 0, seen = 0;
    cyc();
    check("idle_busy", busy, 0);
    check("resp_hold", {bus_error, resp_data}, {last_err, last_data});
    req_mode = t.mode; req_addr = t.addr; req_wdata = t.wdata; req_wstrb = t.wstrb;
    request_enable = 1'b1;
    cyc();
    request_enable = 1'b0;
    fork
      begin
        if (t.mode) slave_write(t);
        else        slave_read(t);
      end
      begin
        while (!seen && lat < 200) begin
          if (m_axi_arvalid) begin
            arv++;
            if (m_axi_araddr !== t.addr || m_axi_arprot !== 3'b000) pay_bad++;
          end
          if (m_axi_arvalid && m_axi_arready) ar_hs++;
          if (m_axi_awvalid) begin
            awv++;
            if (m_axi_awaddr !== t.addr || m_axi_awprot !== 3'b000) pay_bad++;
          end
          if (m_axi_wvalid) begin
            wv++;
            if ({m_axi_wdata, m_axi_wstrb} !== {t.wdata, t.wstrb}) pay_bad++;
          end
          if (m_axi_rready) rr++;
          if (m_axi_bready) begin
            br++;
            if (!(awd && wdn)) bviol++;
          end
          if (m_axi_awvalid && m_axi_awready) awd = 1;
          if (m_axi_wvalid && m_axi_wready) wdn = 1;
          if (!busy) busy_bad++;
          if (response_enable) seen = 1;
          else begin cyc(); lat++; end
        end
      end
    join
    check("latency", lat, t.exp_lat);
    check("resp_data", resp_data, t.exp_data);
    check("bus_error", bus_error, t.exp_err);
    check("payload", pay_bad, 0);
    check("busy_window", busy_bad, 0);
    if (t.mode) begin
      check("awvalid_cycles", awv, t.aw_w + 1);
      check("wvalid_cycles", wv, t.w_w + 1);
      check("bready_cycles", br, t.b_w + 1);
      check("bready_early", bviol, 0);
      check("no_ar_on_write", arv, 0);
    end else begin
      check("arvalid_cycles", arv, t.ar_w + 1);
      check("rready_cycles", rr, t.r_w + 1);
      check("ar_handshakes", ar_hs, 1);
      check("no_aw_on_read", awv + wv, 0);
    end
    last_data = t.exp_data;
    last_err  = t.exp_err;
  endtask

  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    r.exp_data = t.mode ? 32'd0 : t.rdata;
    r.exp_err  = (t.resp != 2'b00);
    r.exp_lat  = t.mode ? 3 + ((t.aw_w > t.w_w) ? t.aw_w : t.w_w) + t.b_w : 3 + t.ar_w + t.r_w;
    return r;
  endfunction

  txn_t tbl [6];

  initial begin
    txn_t rt;
    int   n;
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    txn_t rt;
    int   n;
    //        mode addr          wdata         wstrb   ar r aw w b resp   rdata         inj  exp_data     err lat
    tbl[0] = '{0, 32'h8000_0010, 32'h0,        4'h0,   0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 3};
    tbl[1] = '{1, 32'h4000_0000, 32'h1234_5678, 4'b0011, 0, 0, 2, 0, 0, 2'b00, 32'h0,       0, 32'h0,        0, 5};
    tbl[2] = '{0, 32'h0000_0100, 32'h0,        4'h0,   0, 0, 0, 0, 0, 2'b10, 32'hCAFE_0001, 0, 32'hCAFE_0001, 1, 3};
    tbl[3] = '{1, 32'h0000_0104, 32'hA5A5_5A5A, 4'hF,   0, 0, 0, 0, 0, 2'b00, 32'h0,       0, 32'h0,        0, 3};
    tbl[4] = '{0, 32'h0000_2000, 32'h0,        4'h0,   0, 5, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 0, 8};
    tbl[5] = '{1, 32'h0000_2004, 32'h0000_00FF, 4'b0001, 0, 0, 0, 0, 0, 2'b00, 32'h0,       0, 32'h0,        0, 3};

    repeat (3) cyc();
    check("reset_outputs",
          {response_enable, busy, bus_error, m_axi_arvalid, m_axi_rready,
           m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 8'h00);
    check("reset_regs", {resp_data, m_axi_araddr, m_axi_wdata, m_axi_wstrb}, 100'h0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Reset while waiting for B: everything must drop without a clock.
    cyc();
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    req_mode = 1'b1; req_addr = 32'h0000_3000; req_wdata = 32'h1111_2222; req_wstrb = 4'hF;
    request_enable = 1'b1;
    cyc();
    request_enable = 1'b0;
    n = 0;
    while (!m_axi_bready && n < 20) begin cyc(); n++; end
    check("reached_wresp", m_axi_bready, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_outputs",
          {response_enable, busy, m_axi_arvalid, m_axi_rready,
           m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 7'h00);
    check("async_reset_resp", {bus_error, resp_data}, 33'h0);
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    cyc();
    rstn = 1'b1;
    last_data = '0;
    last_err  = 1'b0;
    rt = tbl[0];
    rt.rdata = 32'h7654_3210;
    run_txn(model(rt));

    for (int i = 0; i < 24; i++) begin
      rt.mode   = 1'($urandom_range(0, 1));
      rt.addr   = $urandom;
      rt.wdata  = $urandom;
      rt.wstrb  = 4'($urandom);
      rt.ar_w   = $urandom_range(0, 3);
      rt.r_w    = $urandom_range(0, 3);
      rt.aw_w   = $urandom_range(0, 3);
      rt.w_w    = $urandom_range(0, 3);
      rt.b_w    = $urandom_range(0, 3);
      rt.resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rt.rdata  = $urandom;
      rt.inject = 0;
      run_txn(model(rt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
